// File: rtl/svm_result_packer.sv
// Upsizing AXI4-Stream packer: gathers 32-bit SVM result words into 512-bit host beats,
// flushing early on input tlast or after an idle timeout with a partially filled beat.
module svm_result_packer #(
   parameter int unsigned FLUSH_TIMEOUT = 1024,
   parameter int unsigned LANES         = 16
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [31:0]         s_axis_tdata,
   input  logic [3:0]          s_axis_tkeep,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic                s_axis_tlast,
   output logic [32*LANES-1:0] m_axis_tdata,
   output logic [4*LANES-1:0]  m_axis_tkeep,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic [31:0]         stat_beats,
   output logic [15:0]         stat_timeouts
);

   localparam int unsigned DW = 32 * LANES;
   localparam int unsigned KW = 4 * LANES;
   localparam int unsigned CW = $clog2(LANES);
   localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);
   localparam logic [31:0]   TO_M1     = 32'(FLUSH_TIMEOUT) - 32'd1;
   localparam bit            TO_EN     = (FLUSH_TIMEOUT != 0);

   logic [DW-1:0] r_data, r_data_d;
   logic [KW-1:0] r_keep, r_keep_d;
   logic [CW-1:0] r_cnt, r_cnt_d;
   logic          r_last, r_last_d;
   logic          r_cmpl, r_cmpl_d;
   logic [31:0]   r_idle, r_idle_d;
   logic          r_s_ready, r_s_ready_d;
   logic [DW-1:0] r_m_data, r_m_data_d;
   logic [KW-1:0] r_m_keep, r_m_keep_d;
   logic          r_m_valid, r_m_valid_d;
   logic          r_m_last, r_m_last_d;
   logic [31:0]   r_beats, r_beats_d;
   logic [15:0]   r_timeouts, r_timeouts_d;

   logic          w_accept;
   logic          w_slot_free;
   logic          w_word_done;
   logic          w_timeout;
   logic          w_beat_last;
   logic [DW-1:0] w_word_data;
   logic [KW-1:0] w_word_keep;
   logic [DW-1:0] w_asm_data;
   logic [KW-1:0] w_asm_keep;

   // Incoming word shifted into its lane; unwritten lanes stay zero so OR-merge is exact.
   assign w_word_data = DW'(s_axis_tdata) << {r_cnt, 5'b0};
   assign w_word_keep = KW'(s_axis_tkeep) << {r_cnt, 2'b0};

   always_comb begin
      w_accept    = s_axis_tvalid & r_s_ready;
      w_slot_free = ~r_m_valid | m_axis_tready;
      w_asm_data  = w_accept ? (r_data | w_word_data) : r_data;
      w_asm_keep  = w_accept ? (r_keep | w_word_keep) : r_keep;
      w_word_done = w_accept & ((r_cnt == LAST_LANE) | s_axis_tlast);
      // A word accepted this cycle always pre-empts the timeout.
      w_timeout   = TO_EN & ~w_accept & ~r_cmpl & (r_cnt != '0) & (r_idle == TO_M1);
      w_beat_last = w_word_done & s_axis_tlast;
   end

   always_comb begin
      r_data_d     = r_data;
      r_keep_d     = r_keep;
      r_cnt_d      = r_cnt;
      r_last_d     = r_last;
      r_cmpl_d     = r_cmpl;
      r_idle_d     = r_idle;
      r_m_data_d   = r_m_data;
      r_m_keep_d   = r_m_keep;
      r_m_last_d   = r_m_last;
      r_m_valid_d  = r_m_valid & ~m_axis_tready;
      r_beats_d    = r_beats + {31'd0, r_m_valid & m_axis_tready};
      r_timeouts_d = r_timeouts;

      if (r_cmpl) begin
         if (w_slot_free) begin
            r_m_data_d  = r_data;
            r_m_keep_d  = r_keep;
            r_m_last_d  = r_last;
            r_m_valid_d = 1'b1;
            r_data_d    = '0;
            r_keep_d    = '0;
            r_cnt_d     = '0;
            r_last_d    = 1'b0;
            r_cmpl_d    = 1'b0;
            r_idle_d    = '0;
         end
      end else if (w_word_done || w_timeout) begin
         r_idle_d = '0;
         if (w_timeout && (r_timeouts != 16'hFFFF)) begin
            r_timeouts_d = r_timeouts + 16'd1;
         end
         if (w_slot_free) begin
            r_m_data_d  = w_asm_data;
            r_m_keep_d  = w_asm_keep;
            r_m_last_d  = w_beat_last;
            r_m_valid_d = 1'b1;
            r_data_d    = '0;
            r_keep_d    = '0;
            r_cnt_d     = '0;
            r_last_d    = 1'b0;
         end else begin
            r_data_d = w_asm_data;
            r_keep_d = w_asm_keep;
            r_last_d = w_beat_last;
            r_cmpl_d = 1'b1;
         end
      end else if (w_accept) begin
         r_data_d = w_asm_data;
         r_keep_d = w_asm_keep;
         r_cnt_d  = r_cnt + CW'(1);
         r_idle_d = '0;
      end else if (TO_EN && (r_cnt != '0)) begin
         r_idle_d = r_idle + 32'd1;
      end

      r_s_ready_d = ~r_cmpl_d;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_data     <= '0;
         r_keep     <= '0;
         r_cnt      <= '0;
         r_last     <= 1'b0;
         r_cmpl     <= 1'b0;
         r_idle     <= '0;
         r_s_ready  <= 1'b0;
         r_m_data   <= '0;
         r_m_keep   <= '0;
         r_m_valid  <= 1'b0;
         r_m_last   <= 1'b0;
         r_beats    <= '0;
         r_timeouts <= '0;
      end else begin
         r_data     <= r_data_d;
         r_keep     <= r_keep_d;
         r_cnt      <= r_cnt_d;
         r_last     <= r_last_d;
         r_cmpl     <= r_cmpl_d;
         r_idle     <= r_idle_d;
         r_s_ready  <= r_s_ready_d;
         r_m_data   <= r_m_data_d;
         r_m_keep   <= r_m_keep_d;
         r_m_valid  <= r_m_valid_d;
         r_m_last   <= r_m_last_d;
         r_beats    <= r_beats_d;
         r_timeouts <= r_timeouts_d;
      end
   end

   assign s_axis_tready = r_s_ready;
   assign m_axis_tdata  = r_m_data;
   assign m_axis_tkeep  = r_m_keep;
   assign m_axis_tvalid = r_m_valid;
   assign m_axis_tlast  = r_m_last;
   assign stat_beats    = r_beats;
   assign stat_timeouts = r_timeouts;

endmodule

// File: tb/tb_svm_result_packer.sv
// Bench for svm_result_packer: directed scenarios plus randomized traffic, checked against a
// word-list model of beat assembly, tlast/full-beat completion and idle-timeout flushing.
module tb_svm_result_packer;

   localparam int unsigned TO = 8;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic [31:0]  s_axis_tdata = '0;
   logic [3:0]   s_axis_tkeep = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic         s_axis_tlast = 1'b0;
   logic [511:0] m_axis_tdata;
   logic [63:0]  m_axis_tkeep;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b0;
   logic         m_axis_tlast;
   logic [31:0]  stat_beats;
   logic [15:0]  stat_timeouts;

   svm_result_packer #(.FLUSH_TIMEOUT(TO), .LANES(16)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .stat_beats    (stat_beats),
      .stat_timeouts (stat_timeouts)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a beat is just the list of accepted words, closed on 16 words,
   // tlast, or TO consecutive idle cycles while words are pending.
   typedef struct {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
   } beat_t;

   beat_t        exp_q[$];
   logic [511:0] p_data = '0;
   logic [63:0]  p_keep = '0;
   int           p_len = 0;
   int           p_idle = 0;
   int unsigned  exp_beats = 0;
   int unsigned  exp_to = 0;
   logic         hold_prev = 1'b0;
   logic [511:0] prev_data;
   logic [63:0]  prev_keep;
   logic         prev_last;

   task automatic push_beat(input logic last);
      beat_t b;
      b.data = p_data;
      b.keep = p_keep;
      b.last = last;
      exp_q.push_back(b);
      p_data = '0;
      p_keep = '0;
      p_len  = 0;
      p_idle = 0;
   endtask

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         exp_q.delete();
         p_data = '0;
         p_keep = '0;
         p_len = 0;
         p_idle = 0;
         exp_beats = 0;
         exp_to = 0;
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", m_axis_tvalid, 1'b1);
            check("hold_data", m_axis_tdata, prev_data);
            check("hold_keep_last", {m_axis_tlast, m_axis_tkeep}, {prev_last, prev_keep});
         end
         hold_prev = m_axis_tvalid && !m_axis_tready;
         prev_data = m_axis_tdata;
         prev_keep = m_axis_tkeep;
         prev_last = m_axis_tlast;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got beat keep %0h, expected no beat", m_axis_tkeep);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               check("beat_data", m_axis_tdata, b.data);
               check("beat_keep", m_axis_tkeep, b.keep);
               check("beat_last", m_axis_tlast, b.last);
               exp_beats++;
            end
         end
         if (s_axis_tvalid && s_axis_tready) begin
            p_data[32*p_len +: 32] = s_axis_tdata;
            p_keep[4*p_len +: 4]   = s_axis_tkeep;
            p_len++;
            p_idle = 0;
            if (p_len == 16 || s_axis_tlast) push_beat(s_axis_tlast);
         end else if (p_len > 0) begin
            p_idle++;
            if (p_idle == TO) begin
               push_beat(1'b0);
               exp_to++;
            end
         end
      end
   end

   always @(negedge aclk) begin
      if (aresetn) begin
         check("stat_beats", stat_beats, exp_beats);
         check("stat_timeouts", stat_timeouts, exp_to);
      end
   end

   bit rnd_mode = 1'b0;
   always @(negedge aclk) begin
      if (rnd_mode) m_axis_tready = ($urandom_range(0, 3) != 0);
   end

   // Starts and ends just after a falling edge; returns after the accepting rising edge.
   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit ok;
      int n;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      ok = 1'b0;
      n = 0;
      while (!ok && n < 1000) begin
         ok = s_axis_tready;
         @(posedge aclk);
         @(negedge aclk);
         n++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no s_axis_tready in %0d cycles, expected acceptance", n);
      end
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (n) @(negedge aclk);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!m_axis_tvalid && n < 50) begin
         @(negedge aclk);
         n++;
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge aclk);
      check("rst_s_ready", s_axis_tready, 1'b0);
      check("rst_m_valid", m_axis_tvalid, 1'b0);
      check("rst_m_data", m_axis_tdata, '0);
      check("rst_m_keep_last", {m_axis_tlast, m_axis_tkeep}, '0);
      check("rst_stats", {stat_beats, stat_timeouts}, '0);
      #2 aresetn = 1'b1;
      @(negedge aclk);
      check("ready_after_release", s_axis_tready, 1'b1);

      // Full beat
      m_axis_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send(32'(i), 4'hF, 1'b0);
         if (i == 14) check("full_no_early_valid", m_axis_tvalid, 1'b0);
      end
      check("full_valid", m_axis_tvalid, 1'b1);
      check("full_lane0", m_axis_tdata[31:0], 32'h0);
      check("full_lane7", m_axis_tdata[255:224], 32'h7);
      check("full_lane15", m_axis_tdata[511:480], 32'hF);
      check("full_keep", m_axis_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
      check("full_last", m_axis_tlast, 1'b0);
      idle(2);
      check("full_stat_beats", stat_beats, 32'd1);

      // Short packet
      send(32'hA, 4'hF, 1'b0);
      send(32'hB, 4'hF, 1'b0);
      send(32'hC, 4'hF, 1'b1);
      check("short_valid", m_axis_tvalid, 1'b1);
      check("short_data", m_axis_tdata[95:0], 96'h0000000C_0000000B_0000000A);
      check("short_upper", m_axis_tdata[511:96], '0);
      check("short_keep", m_axis_tkeep, 64'h0000_0000_0000_0FFF);
      check("short_last", m_axis_tlast, 1'b1);
      idle(3);

      // Backpressure
      m_axis_tready = 1'b0;
      for (int i = 0; i < 32; i++) send(32'h100 + 32'(i), 4'hF, 1'b0);
      s_axis_tvalid = 1'b0;
      check("bp_ready_low", s_axis_tready, 1'b0);
      check("bp_first_held", {m_axis_tvalid, m_axis_tdata[31:0]}, {1'b1, 32'h100});
      m_axis_tready = 1'b1;
      @(negedge aclk);
      check("bp_second", {m_axis_tvalid, m_axis_tdata[31:0]}, {1'b1, 32'h110});
      check("bp_ready_back", s_axis_tready, 1'b1);
      idle(3);

      // Timeout
      for (int i = 0; i < 5; i++) send(32'h200 + 32'(i), 4'hF, 1'b0);
      s_axis_tvalid = 1'b0;
      wait_valid(n);
      check("to_latency", n, TO);
      check("to_keep", m_axis_tkeep, 64'hFFFFF);
      check("to_last", m_axis_tlast, 1'b0);
      check("to_count", stat_timeouts, 16'd1);
      idle(3);

      // Sixth word arrives during idle cycle 7: timer restarts
      for (int i = 0; i < 5; i++) send(32'h280 + 32'(i), 4'hF, 1'b0);
      idle(TO - 2);
      send(32'h285, 4'hF, 1'b0);
      s_axis_tvalid = 1'b0;
      wait_valid(n);
      check("to_restart_latency", n, TO);
      check("to_restart_keep", m_axis_tkeep, 64'hFFFFFF);
      check("to_restart_count", stat_timeouts, 16'd2);
      idle(3);

      // Lane 15 carrying tlast
      for (int i = 0; i < 16; i++) send(32'h600 + 32'(i), 4'hF, i == 15);
      check("l15_valid", m_axis_tvalid, 1'b1);
      check("l15_keep_last", {m_axis_tlast, m_axis_tkeep}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
      n = int'(stat_beats);
      idle(20);
      check("l15_single_beat", stat_beats, 32'(n + 1));

      // Reset mid-beat with a held output beat
      m_axis_tready = 1'b0;
      for (int i = 0; i < 23; i++) send(32'h300 + 32'(i), 4'hF, 1'b0);
      s_axis_tvalid = 1'b0;
      #2 aresetn = 1'b0;
      #1;
      check("mid_rst_valid_ready", {m_axis_tvalid, s_axis_tready}, 2'b00);
      check("mid_rst_data", m_axis_tdata, '0);
      check("mid_rst_keep_last", {m_axis_tlast, m_axis_tkeep}, '0);
      check("mid_rst_stats", {stat_beats, stat_timeouts}, '0);
      @(negedge aclk);
      #2 aresetn = 1'b1;
      m_axis_tready = 1'b1;
      @(negedge aclk);
      check("post_rst_no_stale", m_axis_tvalid, 1'b0);
      for (int i = 0; i < 16; i++) send(32'h500 + 32'(i), 4'hF, 1'b0);
      check("post_rst_lane0", m_axis_tdata[31:0], 32'h500);
      check("post_rst_lane15", m_axis_tdata[511:480], 32'h50F);
      check("post_rst_keep", m_axis_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
      idle(5);
      check("post_rst_beats", stat_beats, 32'd1);

      // Randomized traffic with random output stalls
      rnd_mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         int r;
         send($urandom, 4'($urandom_range(1, 15)), ($urandom_range(0, 9) == 0));
         r = $urandom_range(0, 19);
         if (r >= 18) idle($urandom_range(TO - 2, TO + 4));
         else if (r >= 12) idle($urandom_range(1, 3));
      end
      rnd_mode = 1'b0;
      m_axis_tready = 1'b1;
      idle(40);
      check("drain_empty", exp_q.size(), 0);
      check("drain_partial", p_len, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by 500000, expected earlier finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
